dm_cache: RTL and testbench
===========================

Name: dm_cache

Overview:
- Responder end of the pipeline's word-memory interface: services `mem_read`/`mem_write` requests with a one-cycle `mem_resp` pulse.
- Direct-mapped, write-back, write-allocate cache: 8 sets of 16-byte (128-bit) lines.
- Misses go to physical memory over a line-wide read/write handshake.
- One instance serves the I-side and one the D-side; the I-side instance ties `mem_write` low.

Parameters:
- `S_INDEX`, default 3, log2 number of sets (8 sets).
- `S_OFFSET`, default 4, log2 line bytes (16 B, 128-bit line). Fixed at 4 in this revision.

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high; sampled on rising edge of `clk`.
- `mem_address` input 16: CPU byte address; bit 0 ignored.
- `mem_read` input 1: read request, held until `mem_resp`.
- `mem_write` input 1: write request, held until `mem_resp`.
- `mem_byte_enable` input 2: write byte mask; bit0 = low byte, bit1 = high byte.
- `mem_wdata` input 16: write data.
- `mem_rdata` output 16: read data, valid when `mem_resp`=1.
- `mem_resp` output 1: one-cycle completion pulse.
- `pmem_address` output 16: line address; low 4 bits are always 0.
- `pmem_read` output 1: line fill request, held until `pmem_resp`.
- `pmem_write` output 1: line writeback request, held until `pmem_resp`.
- `pmem_wdata` output 128: victim line.
- `pmem_rdata` input 128: fill line, valid when `pmem_resp`=1.
- `pmem_resp` input 1: physical memory completion pulse.

Behaviour:
- Address split: tag = `[15:7]` (9 b), index = `[6:4]`, word = `[3:1]`.
- Per set: valid, dirty, tag[8:0], data[127:0]. Word w occupies bits `[16w+15:16w]`.
- Reset:
  - All valid and dirty bits cleared; state = IDLE.
  - Outputs: `mem_resp`, `pmem_read`, `pmem_write` = 0; `mem_rdata`, `pmem_wdata` = don't-care.
  - Tag and data arrays are not cleared.
  - Reset mid-miss aborts the transaction; the strobes drop on the first cycle after the reset edge.
- FSM states: IDLE, WRITEBACK, FILL.
- Hit is defined as valid[index] && tag[index]==tag.
- IDLE:
  - Request with hit: `mem_resp`=1 combinationally in the same cycle (0-cycle hit latency).
  - Hit read: `mem_rdata` = selected word.
  - Hit write: at the clock edge, update the bytes enabled by `mem_byte_enable` in the selected word and set dirty. `mem_byte_enable`=00 responds without modifying data or dirty.
  - Miss with victim not dirty (or invalid): go to FILL.
  - Miss with victim valid and dirty: go to WRITEBACK.
  - No request: stay in IDLE, all strobes 0.
- WRITEBACK:
  - `pmem_write`=1, `pmem_address`={stored tag, index, 4'b0}, `pmem_wdata`=stored line.
  - On `pmem_resp`: clear dirty, go to FILL.
- FILL:
  - `pmem_read`=1, `pmem_address`={request tag, index, 4'b0}.
  - On `pmem_resp`: load data=`pmem_rdata`, tag=request tag, valid=1, dirty=0, go to IDLE.
  - The request then hits in IDLE on the next cycle.
- Miss latency: writeback latency (if dirty) + fill latency + 1 cycle.
- `mem_resp` is never asserted outside IDLE.
- `pmem_read` and `pmem_write` are never both 1.
- `mem_read` and `mem_write` both asserted: treated as a write.
- CPU request dropped or changed during a miss: a protocol violation. The in-flight pmem transaction completes regardless, and the cache returns to IDLE.
- `pmem_resp` while in IDLE: ignored.

Decomposition:
- Add to package `lc3b_types`:
  - `lc3b_c_tag` [8:0]
  - `lc3b_c_index` [2:0]
  - `lc3b_c_offset` [3:0]
  - `lc3b_c_line` [127:0]
- Sub-module `cache_control`: FSM only. Inputs: hit, dirty, request, `pmem_resp`. Outputs: array load enables, pmem address select, `mem_resp`, `pmem_read`, `pmem_write`.
- Arrays and word/byte merge logic live in the top level.

Test Plan:
- Cold read: after reset, read 0x0082, pmem returns line with word1=0xBEEF after 3 cycles. Expect `pmem_read` with `pmem_address`=0x0080, no `pmem_write`, `mem_resp` one cycle after `pmem_resp`, `mem_rdata`=0xBEEF.
- Hit: read 0x0084 immediately after the fill. Expect `mem_resp` in the same cycle, no pmem activity.
- Byte write: write 0x0082, `mem_wdata`=0x1234, `mem_byte_enable`=01 on resident word 0xBEEF. Expect `mem_resp` same cycle; subsequent read of 0x0082 = 0xBE34.
- Dirty eviction: access 0x0182 (same index, new tag). Expect `pmem_write` at 0x0080 with `pmem_wdata[31:16]`=0xBE34, then `pmem_read` at 0x0180, then `mem_resp`.
- Clean eviction: evict the now-clean 0x0180 line with 0x0282. Expect `pmem_read` only, no `pmem_write`.
- Reset mid-fill: assert `reset` while `pmem_read`=1. Expect `pmem_read`=0 from the first cycle after the reset edge. A re-read of 0x0182 misses.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared cache types for the LC-3b memory hierarchy.
package lc3b_types;

  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [3:0]   lc3b_c_offset;
  typedef logic [127:0] lc3b_c_line;

  typedef enum logic [1:0] {
    CC_IDLE,
    CC_WRITEBACK,
    CC_FILL
  } cc_state_e;

endpackage

// File: rtl/cache_control.sv
// Miss-handling sequencer for the direct-mapped cache.
//   state     | meaning
//   IDLE      | serve hits, detect misses
//   WRITEBACK | push dirty victim line to physical memory
//   FILL      | fetch requested line from physical memory
module cache_control
  import lc3b_types::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic hit_i,
  input  logic dirty_i,
  input  logic request_i,
  input  logic pmem_resp_i,
  output logic fill_load_o,
  output logic wb_done_o,
  output logic addr_sel_wb_o,
  output logic mem_resp_o,
  output logic pmem_read_o,
  output logic pmem_write_o
);

  cc_state_e state_q;
  logic      pmem_read_q;
  logic      pmem_write_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= CC_IDLE;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      case (state_q)
        CC_IDLE: begin
          if (request_i && !hit_i) begin
            if (dirty_i) begin
              state_q      <= CC_WRITEBACK;
              pmem_write_q <= 1'b1;
            end else begin
              state_q     <= CC_FILL;
              pmem_read_q <= 1'b1;
            end
          end
        end
        CC_WRITEBACK: begin
          if (pmem_resp_i) begin
            state_q      <= CC_FILL;
            pmem_write_q <= 1'b0;
            pmem_read_q  <= 1'b1;
          end
        end
        CC_FILL: begin
          if (pmem_resp_i) begin
            state_q     <= CC_IDLE;
            pmem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= CC_IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Hit response must be same-cycle, so it cannot wait for a register.
  assign mem_resp_o    = (state_q == CC_IDLE) && request_i && hit_i;
  assign fill_load_o   = (state_q == CC_FILL) && pmem_resp_i;
  assign wb_done_o     = (state_q == CC_WRITEBACK) && pmem_resp_i;
  assign addr_sel_wb_o = (state_q == CC_WRITEBACK);
  assign pmem_read_o   = pmem_read_q;
  assign pmem_write_o  = pmem_write_q;

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-back, write-allocate cache: tag/data arrays and word merge;
// miss sequencing lives in cache_control.
module dm_cache
  import lc3b_types::*;
#(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 16 - S_INDEX - S_OFFSET;

  logic [TAG_W-1:0]   req_tag;
  logic [S_INDEX-1:0] req_idx;
  logic [2:0]         req_word;
  logic               unused_addr_lsb;

  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  lc3b_c_line         data_q [SETS];

  logic       hit, victim_dirty, request, hit_write;
  logic       fill_load, wb_done, addr_sel_wb;
  lc3b_c_line cur_line, merged_line;
  logic [15:0] cur_word, new_word;

  assign req_tag         = mem_address[15 -: TAG_W];
  assign req_idx         = mem_address[S_OFFSET +: S_INDEX];
  assign req_word        = mem_address[S_OFFSET-1:1];
  assign unused_addr_lsb = mem_address[0];

  assign request      = mem_read | mem_write;
  assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  // A simultaneous read+write is a write; an empty byte mask leaves the line clean.
  assign hit_write    = mem_resp && mem_write && (|mem_byte_enable);

  cache_control u_ctrl (
    .clk_i         (clk),
    .reset_i       (reset),
    .hit_i         (hit),
    .dirty_i       (victim_dirty),
    .request_i     (request),
    .pmem_resp_i   (pmem_resp),
    .fill_load_o   (fill_load),
    .wb_done_o     (wb_done),
    .addr_sel_wb_o (addr_sel_wb),
    .mem_resp_o    (mem_resp),
    .pmem_read_o   (pmem_read),
    .pmem_write_o  (pmem_write)
  );

  always_comb begin
    cur_line = data_q[req_idx];
    cur_word = cur_line[{req_word, 4'b0000} +: 16];
    new_word = cur_word;
    if (mem_byte_enable[0]) new_word[7:0]  = mem_wdata[7:0];
    if (mem_byte_enable[1]) new_word[15:8] = mem_wdata[15:8];
    merged_line = cur_line;
    merged_line[{req_word, 4'b0000} +: 16] = new_word;
  end

  assign mem_rdata    = cur_word;
  assign pmem_wdata   = cur_line;
  assign pmem_address = addr_sel_wb ? {tag_q[req_idx], req_idx, {S_OFFSET{1'b0}}}
                                    : {req_tag,        req_idx, {S_OFFSET{1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_load) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= 1'b0;
    end else if (wb_done) begin
      dirty_q[req_idx] <= 1'b0;
    end else if (hit_write) begin
      dirty_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data storage are never reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_load) begin
      data_q[req_idx] <= pmem_rdata;
      tag_q[req_idx]  <= req_tag;
    end else if (hit_write) begin
      data_q[req_idx] <= merged_line;
    end
  end

endmodule

// File: tb/tb_dm_cache.sv
// Self-checking bench for dm_cache: directed scenarios then random traffic against a
// word-level memory model plus a set directory of the expected cache residency.
module tb_dm_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  dm_cache dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  int checks = 0;
  int errors = 0;

  // Architectural view of every CPU word, and physical memory contents.
  logic [15:0]  ref_mem [32768];
  logic [127:0] bmem [int];
  bit           mvalid [8];
  bit           mdirty [8];
  logic [8:0]   mtag   [8];

  logic [15:0]  r_rdata;
  int           r_fills, r_wbs, r_cycles;
  logic [15:0]  r_wb_addr, r_fill_addr;
  logic [127:0] r_wb_data;

  function automatic logic [15:0] init_word(int widx);
    logic [15:0] w;
    w = 16'(widx);
    return (w * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [127:0] backing_line(int ln);
    logic [127:0] l;
    if (bmem.exists(ln)) return bmem[ln];
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = init_word(ln*8 + w);
    return l;
  endfunction

  function automatic logic [127:0] ref_line(int ln);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = ref_mem[ln*8 + w];
    return l;
  endfunction

  task automatic chk_l(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One CPU access, serviced by a pmem responder with fixed latency 'lat'.
  // Entered and left just after a rising edge.
  task automatic access(input logic [15:0] a, input bit rd, input bit wr,
                        input logic [1:0] be, input logic [15:0] wd, input int lat);
    int         cnt;
    bit         done;
    logic [8:0] t;
    logic [2:0] ix;
    bit         exp_hit, exp_wb;
    int         widx;
    t       = a[15:7];
    ix      = a[6:4];
    widx    = int'(a[15:1]);
    exp_hit = mvalid[ix] && (mtag[ix] == t);
    exp_wb  = !exp_hit && mvalid[ix] && mdirty[ix];
    r_fills = 0; r_wbs = 0; r_cycles = -1; cnt = 0; done = 0;
    mem_address = a; mem_read = rd; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      pmem_resp = 1'b0;
      chk_i("strobe_excl", int'(pmem_read & pmem_write), 0);
      if (mem_resp) begin
        done = 1; r_cycles = c; r_rdata = mem_rdata;
      end else if (pmem_write) begin
        if (cnt == 0) begin r_wb_addr = pmem_address; r_wb_data = pmem_wdata; end
        cnt++;
        if (cnt >= lat) begin
          bmem[int'(pmem_address[15:4])] = pmem_wdata;
          pmem_resp = 1'b1; cnt = 0; r_wbs++;
        end
      end else if (pmem_read) begin
        if (cnt == 0) r_fill_addr = pmem_address;
        cnt++;
        if (cnt >= lat) begin
          pmem_rdata = backing_line(int'(pmem_address[15:4]));
          pmem_resp = 1'b1; cnt = 0; r_fills++;
        end
      end
    end
    chk_i("timeout", int'(done), 1);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    if (!wr) chk_w("rdata", r_rdata, ref_mem[widx]);
    chk_i("fills", r_fills, exp_hit ? 0 : 1);
    chk_i("wbs", r_wbs, int'(exp_wb));
    chk_i("latency", r_cycles, exp_hit ? 0 : ((exp_wb ? 2*lat : lat) + 1));
    if (exp_wb) begin
      chk_w("wb_addr", r_wb_addr, {mtag[ix], ix, 4'b0000});
      chk_l("wb_data", r_wb_data, ref_line(int'({mtag[ix], ix})));
    end
    if (!exp_hit) chk_w("fill_addr", r_fill_addr, {t, ix, 4'b0000});
    if (!exp_hit) begin
      mvalid[ix] = 1; mtag[ix] = t; mdirty[ix] = 0;
    end
    if (wr && be != 2'b00) begin
      mdirty[ix] = 1;
      if (be[0]) ref_mem[widx][7:0]  = wd[7:0];
      if (be[1]) ref_mem[widx][15:8] = wd[15:8];
    end
  endtask

  // Dirty data that never reached physical memory is lost on reset.
  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      if (mvalid[s] && mdirty[s]) begin
        logic [127:0] l;
        int ln;
        ln = int'({mtag[s], 3'(s)});
        l  = backing_line(ln);
        for (int w = 0; w < 8; w++) ref_mem[ln*8 + w] = l[w*16 +: 16];
      end
      mvalid[s] = 0; mdirty[s] = 0;
    end
  endtask

  initial begin
    logic [127:0] l;
    bit seen;
    reset = 1'b1; mem_address = '0; mem_read = 0; mem_write = 0;
    mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(i);
    for (int s = 0; s < 8; s++) begin mvalid[s] = 0; mdirty[s] = 0; mtag[s] = '0; end
    l = backing_line(8);
    l[31:16] = 16'hBEEF;
    bmem[8] = l;
    ref_mem[8*8 + 1] = 16'hBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("rst_mem_resp", int'(mem_resp), 0);
    chk_i("rst_pmem_read", int'(pmem_read), 0);
    chk_i("rst_pmem_write", int'(pmem_write), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Cold read
    access(16'h0082, 1, 0, 2'b00, 16'h0000, 3);
    chk_w("cold_rdata", r_rdata, 16'hBEEF);
    chk_w("cold_fill_addr", r_fill_addr, 16'h0080);
    chk_i("cold_latency", r_cycles, 4);
    // Hit
    access(16'h0084, 1, 0, 2'b00, 16'h0000, 3);
    chk_i("hit_latency", r_cycles, 0);
    // Byte write then read back
    access(16'h0082, 0, 1, 2'b01, 16'h1234, 3);
    chk_i("bytewr_latency", r_cycles, 0);
    access(16'h0082, 1, 0, 2'b00, 16'h0000, 3);
    chk_w("bytewr_rdata", r_rdata, 16'hBE34);
    // Dirty eviction
    access(16'h0182, 1, 0, 2'b00, 16'h0000, 2);
    chk_i("dirty_wbs", r_wbs, 1);
    chk_w("dirty_wb_addr", r_wb_addr, 16'h0080);
    chk_w("dirty_wb_word1", r_wb_data[31:16], 16'hBE34);
    chk_w("dirty_fill_addr", r_fill_addr, 16'h0180);
    // Clean eviction
    access(16'h0282, 1, 0, 2'b00, 16'h0000, 2);
    chk_i("clean_wbs", r_wbs, 0);
    chk_i("clean_fills", r_fills, 1);

    // Stray pmem_resp while idle must be ignored
    @(negedge clk);
    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk_i("stray_pmem_read", int'(pmem_read), 0);
    chk_i("stray_pmem_write", int'(pmem_write), 0);
    @(posedge clk); #1;
    access(16'h0286, 1, 0, 2'b00, 16'h0000, 2);

    // Reset during a fill
    mem_address = 16'h0182; mem_read = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = pmem_read;
    end
    chk_i("midfill_seen", int'(seen), 1);
    reset = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    chk_i("midfill_pmem_read", int'(pmem_read), 0);
    chk_i("midfill_pmem_write", int'(pmem_write), 0);
    chk_i("midfill_mem_resp", int'(mem_resp), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    access(16'h0182, 1, 0, 2'b00, 16'h0000, 2);
    chk_i("postreset_fills", r_fills, 1);

    // Random traffic over a few tags per set to mix hits, clean and dirty misses
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      int op;
      a  = {7'($urandom_range(0, 3)), 2'b00, 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      op = $urandom_range(0, 3);
      access(a, op != 1, op != 0, 2'($urandom_range(0, 3)),
             16'($urandom), $urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
